// File: rtl/invaders_pkg.sv
// Shared types and screen geometry for the invaders game blocks.
// Missile slot states and screen bounds live here.
package invaders_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLYING  = 2'd1,
    EXPLODE = 2'd2
  } missile_state_t;

endpackage

// File: rtl/pmissile_controller_if.sv
// Bus between ship/collision logic and the player missile controller.
// Master drives fire/position/hits; slave returns missile sprites.
interface pmissile_controller_if #(
  parameter int N = 2
);
  logic            pmissile_create;
  logic [9:0]      player_x;
  logic [N-1:0]    hit_mask;
  logic [10*N-1:0] missile_x;
  logic [10*N-1:0] missile_y;
  logic [N-1:0]    missile_active;
  logic [N-1:0]    missile_exploding;
  logic            shot_fired;

  modport master (
    output pmissile_create, player_x, hit_mask,
    input  missile_x, missile_y, missile_active,
    input  missile_exploding, shot_fired
  );

  modport slave (
    input  pmissile_create, player_x, hit_mask,
    output missile_x, missile_y, missile_active,
    output missile_exploding, shot_fired
  );
endinterface

// File: rtl/pmissile_slot.sv
// One player missile: launch, upward stepping, hit explosion, retire.
// x is latched at launch and never follows the ship afterwards.
module pmissile_slot
  import invaders_pkg::*;
#(
  parameter int SPEED          = 8,
  parameter int LAUNCH_Y       = 440,
  parameter int Y_TOP          = 16,
  parameter int EXPLODE_FRAMES = 8
) (
  input  logic           vsync,
  input  logic           reset,
  input  logic           launch,
  input  logic [9:0]     launch_x,
  input  logic           hit,
  output logic [9:0]     x,
  output logic [9:0]     y,
  output missile_state_t state
);

  localparam int EW =
    (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;

  missile_state_t state_n;
  logic [9:0]     x_n;
  logic [9:0]     y_n;
  logic [EW-1:0]  cnt, cnt_n;

  always_ff @(posedge vsync or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      x     <= x_n;
      y     <= y_n;
      cnt   <= cnt_n;
    end
  end

  // Retire test runs before the subtract so y never wraps.
  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (launch) begin
          state_n = FLYING;
          x_n     = launch_x;
          y_n     = 10'(LAUNCH_Y);
        end
      end
      FLYING: begin
        if (hit) begin
          state_n = EXPLODE;
          cnt_n   = '0;
        end else if (y < 10'(Y_TOP + SPEED)) begin
          state_n = IDLE;
        end else begin
          y_n = y - 10'(SPEED);
        end
      end
      EXPLODE: begin
        if (cnt == EW'(EXPLODE_FRAMES - 1)) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/pmissile_controller.sv
// Player missile controller: fire edge detect, cooldown, slot pick.
// Slots step once per vsync; outputs packed for renderer/collision.
module pmissile_controller
  import invaders_pkg::*;
#(
  parameter int NUM_MISSILES   = 2,
  parameter int SPEED          = 8,
  parameter int COOLDOWN       = 15,
  parameter int X_OFFSET       = 15,
  parameter int LAUNCH_Y       = 440,
  parameter int Y_TOP          = 16,
  parameter int EXPLODE_FRAMES = 8
) (
  input  logic vsync,
  input  logic reset,
  pmissile_controller_if.slave bus
);

  localparam int CW = $clog2(COOLDOWN + 1);

  missile_state_t          st [NUM_MISSILES];
  logic [9:0]              sx [NUM_MISSILES];
  logic [9:0]              sy [NUM_MISSILES];
  logic [NUM_MISSILES-1:0] free_sel;
  logic [NUM_MISSILES-1:0] launch;
  logic                    any_idle;
  logic                    accept;
  logic                    fire_prev;
  logic [CW-1:0]           cooldown;
  logic [10:0]             x_sum;
  logic [9:0]              launch_x;

  // Lowest-index slot idle at frame start wins.
  always_comb begin
    free_sel = '0;
    any_idle = 1'b0;
    for (int i = 0; i < NUM_MISSILES; i++) begin
      if (st[i] == IDLE && !any_idle) begin
        free_sel[i] = 1'b1;
        any_idle    = 1'b1;
      end
    end
  end

  assign accept = bus.pmissile_create && !fire_prev
               && (cooldown == '0) && any_idle;
  assign launch = accept ? free_sel : '0;

  assign x_sum    = {1'b0, bus.player_x} + 11'(X_OFFSET);
  assign launch_x = (x_sum > 11'(SCREEN_W - 1))
                  ? 10'(SCREEN_W - 1) : x_sum[9:0];

  // fire_prev resets high so a key held through reset does not fire.
  always_ff @(posedge vsync or posedge reset) begin
    if (reset) begin
      fire_prev      <= 1'b1;
      cooldown       <= '0;
      bus.shot_fired <= 1'b0;
    end else begin
      fire_prev      <= bus.pmissile_create;
      bus.shot_fired <= accept;
      if (accept)
        cooldown <= CW'(COOLDOWN);
      else if (cooldown != '0)
        cooldown <= cooldown - 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_MISSILES; i++) begin : g_slot
    pmissile_slot #(
      .SPEED          (SPEED),
      .LAUNCH_Y       (LAUNCH_Y),
      .Y_TOP          (Y_TOP),
      .EXPLODE_FRAMES (EXPLODE_FRAMES)
    ) u_slot (
      .vsync    (vsync),
      .reset    (reset),
      .launch   (launch[i]),
      .launch_x (launch_x),
      .hit      (bus.hit_mask[i]),
      .x        (sx[i]),
      .y        (sy[i]),
      .state    (st[i])
    );

    assign bus.missile_x[10*i +: 10]  = sx[i];
    assign bus.missile_y[10*i +: 10]  = sy[i];
    assign bus.missile_active[i]    = (st[i] == FLYING);
    assign bus.missile_exploding[i] = (st[i] == EXPLODE);
  end

endmodule
